// File: rtl/esn_pkg.sv
// Shared ESN constants: default fixed-point format, Q-format limits and the
// readout state encoding.
package esn_pkg;

    localparam int ESN_DATA_WIDTH = 16;
    localparam int ESN_FRAC_BITS  = 12;

    localparam logic [ESN_DATA_WIDTH-1:0] Q_MAX = 16'h7FFF;
    localparam logic [ESN_DATA_WIDTH-1:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_ROUND,
        ST_OUT
    } esn_state_e;

endpackage

// File: rtl/esn_round_sat.sv
// Combinational round-half-up and saturate from a wide signed accumulator
// down to a DATA_WIDTH signed fixed-point value.
module esn_round_sat #(
    parameter int ACC_WIDTH  = 35,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 12
) (
    input  logic [ACC_WIDTH-1:0]  acc_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    // One guard bit so adding the half-LSB can never wrap.
    localparam logic signed [ACC_WIDTH:0] HALF =
        (ACC_WIDTH+1)'(1) << (FRAC_BITS-1);
    localparam logic signed [ACC_WIDTH:0] SAT_HI =
        {{(ACC_WIDTH+2-DATA_WIDTH){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_LO =
        {{(ACC_WIDTH+2-DATA_WIDTH){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] biased;
    logic signed [ACC_WIDTH:0] shifted;

    assign biased  = $signed({acc_i[ACC_WIDTH-1], acc_i}) + HALF;
    assign shifted = biased >>> FRAC_BITS;

    always_comb begin
        data_o = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_HI) begin
            data_o = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (shifted < SAT_LO) begin
            data_o = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    end

endmodule

// File: rtl/esn_readout.sv
// ESN linear readout: MACs N_NEURONS state beats against a programmable
// weight vector, then rounds/saturates and presents one sample on valid/ready.
module esn_readout
    import esn_pkg::*;
#(
    parameter int DATA_WIDTH = ESN_DATA_WIDTH,
    parameter int FRAC_BITS  = ESN_FRAC_BITS,
    parameter int N_NEURONS  = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N_NEURONS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic                         i_w_we,
    input  logic [$clog2(N_NEURONS)-1:0] i_w_addr,
    input  logic [DATA_WIDTH-1:0]        i_w_data,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_valid,
    input  logic                         i_ready
);

    localparam int CNT_W  = $clog2(N_NEURONS);
    localparam int PROD_W = 2*DATA_WIDTH;

    esn_state_e                  state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [ACC_WIDTH-1:0]        acc_q;
    logic [ACC_WIDTH-1:0]        acc_d;
    logic [DATA_WIDTH-1:0]       w_q [N_NEURONS];
    logic [DATA_WIDTH-1:0]       data_q;
    logic                        valid_q;
    logic signed [PROD_W-1:0]    prod;
    logic [DATA_WIDTH-1:0]       rs_data;
    logic                        in_accum;
    logic                        beat;
    logic                        last_beat;
    logic                        w_wr;

    assign in_accum  = (state_q == ST_ACCUM);
    // Gated by rst so the port reads 0 throughout reset, not only after it.
    assign o_ready   = in_accum & ~rst;
    assign beat      = i_valid & in_accum;
    assign last_beat = (cnt_q == CNT_W'(N_NEURONS-1));
    assign w_wr      = i_w_we & in_accum & (cnt_q == '0)
                     & (int'(i_w_addr) < N_NEURONS);

    assign prod  = $signed(i_data) * $signed(w_q[cnt_q]);
    assign acc_d = acc_q + {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};

    assign o_data  = data_q;
    assign o_valid = valid_q;

    esn_round_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_round_sat (
        .acc_i  (acc_q),
        .data_o (rs_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (beat) begin
                        acc_q <= acc_d;
                        if (last_beat) begin
                            cnt_q   <= '0;
                            state_q <= ST_ROUND;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_ROUND: begin
                    data_q  <= rs_data;
                    valid_q <= 1'b1;
                    state_q <= ST_OUT;
                end
                ST_OUT: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        acc_q   <= '0;
                        state_q <= ST_ACCUM;
                    end
                end
                default: state_q <= ST_ACCUM;
            endcase
        end
    end

    // A beat in the same cycle as a w[0] write reads the pre-write weight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                w_q[i] <= '0;
            end
        end else if (w_wr) begin
            w_q[i_w_addr] <= i_w_data;
        end
    end

endmodule

// File: tb/tb_esn_readout.sv
// Directed bench for esn_readout with a transaction-level reference model
// and literal expectations for each test scenario.
module tb_esn_readout;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic        i_w_we;
    logic [2:0]  i_w_addr;
    logic [15:0] i_w_data;
    logic [15:0] o_data;
    logic        o_valid;
    logic        i_ready;

    int n_vec = 0;
    int n_err = 0;

    esn_readout dut (
        .clk      (clk),
        .rst      (rst),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_w_we   (i_w_we),
        .i_w_addr (i_w_addr),
        .i_w_data (i_w_data),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready)
    );

    always #5 clk = ~clk;

    // Reference model: weights array, running integer dot product, and a
    // pending/presented output sample.
    logic [15:0] m_w [N];
    int          m_cnt;
    longint      m_sum;
    bit          m_pend;
    bit          m_valid;
    logic [15:0] m_pend_data;
    logic [15:0] m_data;

    function automatic logic [15:0] rnd_sat(input longint s);
        longint r;
        r = (s + 2048) >>> 12;
        if (r > 32767)       r = 32767;
        else if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_w[i] = 16'h0;
            m_cnt   = 0;
            m_sum   = 0;
            m_pend  = 0;
            m_valid = 0;
        end else if (m_valid) begin
            if (i_ready) m_valid = 0;
        end else if (m_pend) begin
            m_valid = 1;
            m_data  = m_pend_data;
            m_pend  = 0;
        end else begin
            bit wr_ok;
            wr_ok = i_w_we && (m_cnt == 0);
            if (i_valid) begin
                m_sum += longint'($signed(i_data)) * longint'($signed(m_w[m_cnt]));
                m_cnt++;
                if (m_cnt == N) begin
                    m_pend_data = rnd_sat(m_sum);
                    m_pend      = 1;
                    m_cnt       = 0;
                    m_sum       = 0;
                end
            end
            if (wr_ok) m_w[i_w_addr] = i_w_data;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        chk("o_ready", 16'(o_ready), 16'(!rst && !m_pend && !m_valid));
        chk("o_valid", 16'(o_valid), 16'(m_valid));
        if (m_valid) chk("o_data", o_data, m_data);
    end

    task automatic wr(input int a, input logic [15:0] d);
        i_w_we   = 1'b1;
        i_w_addr = a[2:0];
        i_w_data = d;
        @(negedge clk);
        i_w_we   = 1'b0;
    endtask

    task automatic wr_all(input logic [15:0] d);
        for (int i = 0; i < N; i++) wr(i, d);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!o_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!o_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: o_ready got 0, expected 1");
        end
    endtask

    task automatic beat(input logic [15:0] d);
        wait_ready();
        i_valid = 1'b1;
        i_data  = d;
        @(negedge clk);
        i_valid = 1'b0;
        i_data  = 16'($urandom);
    endtask

    task automatic sample(input logic [15:0] d0, input logic [15:0] drest, input int gapmax);
        for (int b = 0; b < N; b++) begin
            beat((b == 0) ? d0 : drest);
            repeat ($urandom_range(0, gapmax)) @(negedge clk);
        end
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!o_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic take(input string name, input logic [15:0] lit);
        wait_valid();
        chk({name, "_valid"}, 16'(o_valid), 16'h1);
        chk(name, o_data, lit);
        chk({name, "_model"}, m_data, lit);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nv;
        logic [15:0] cap;

        rst = 1'b1; i_data = 16'h0; i_valid = 1'b0; i_w_we = 1'b0;
        i_w_addr = 3'd0; i_w_data = 16'h0; i_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_o_ready", 16'(o_ready), 16'h0);
        chk("rst_o_valid", 16'(o_valid), 16'h0);
        chk("rst_o_data", o_data, 16'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 16'(o_ready), 16'h1);
        @(negedge clk);

        // 1: 8 x 0.5 x 1.0 = 4.0, i_ready held high
        wr_all(16'h1000);
        i_ready = 1'b1;
        sample(16'h0800, 16'h0800, 0);
        nv = 0; cap = 16'h0;
        repeat (6) begin
            @(negedge clk);
            if (o_valid) begin nv++; cap = o_data; end
        end
        i_ready = 1'b0;
        chk("t1_valid_cycles", 16'(nv), 16'h1);
        chk("t1_data", cap, 16'h4000);

        // 2: saturation both ways
        wr_all(16'h7FFF);
        sample(16'h7FFF, 16'h7FFF, 0);
        take("t2_pos", 16'h7FFF);
        sample(16'h8000, 16'h8000, 1);
        take("t2_neg", 16'h8000);

        // 3: rounding at the half-LSB boundary
        wr(0, 16'h0001);
        for (int i = 1; i < N; i++) wr(i, 16'h0000);
        sample(16'h0800, 16'h7FFF, 0);
        take("t3_half_up", 16'h0001);
        sample(16'h07FF, 16'h1234, 0);
        take("t3_below", 16'h0000);
        sample(16'hF800, 16'h8000, 0);
        take("t3_neg_half", 16'h0000);

        // 4: backpressure, extra beats must not be consumed
        wr(0, 16'h1000);
        sample(16'h0800, 16'h0800, 0);
        wait_valid();
        cap = o_data;
        chk("t4_data", cap, 16'h0800);
        for (int c = 0; c < 20; c++) begin
            i_valid = 1'b1;
            i_data  = 16'($urandom);
            @(negedge clk);
            chk("t4_hold_data", o_data, 16'h0800);
            chk("t4_hold_ready", 16'(o_ready), 16'h0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        sample(16'h0400, 16'h7FFF, 0);
        take("t4_next_cnt0", 16'h0400);

        // 5: mixed-sign weights, gaps, ignored mid-sample writes
        for (int i = 0; i < N; i++) wr(i, (i % 2 == 1) ? 16'hF000 : 16'h1000);
        for (int b = 0; b < N; b++) begin
            beat(16'h1000);
            if (b == 2) begin
                wr(0, 16'h7FFF);
                wr(3, 16'h7FFF);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        take("t5_a", 16'h0000);
        wait_ready();
        i_valid = 1'b1; i_data = 16'h1000;
        i_w_we = 1'b1; i_w_addr = 3'd0; i_w_data = 16'h2000;
        @(negedge clk);
        i_valid = 1'b0; i_w_we = 1'b0;
        for (int b = 1; b < N; b++) begin
            beat(16'h1000);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        take("t5_b_old_w0", 16'h0000);
        sample(16'h1000, 16'h1000, 2);
        take("t5_c_new_w0", 16'h1000);

        // 6: reset mid-sample discards accumulation and clears weights
        wr_all(16'h1000);
        for (int b = 0; b < 3; b++) beat(16'h0800);
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", 16'(o_ready), 16'h0);
        chk("t6_rst_valid", 16'(o_valid), 16'h0);
        chk("t6_rst_data", o_data, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sample(16'h0800, 16'h0800, 0);
        take("t6_zero_w", 16'h0000);
        wr_all(16'h1000);
        sample(16'h0800, 16'h0800, 1);
        take("t6_reprog", 16'h4000);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/esn_readout.md
# esn_readout

Linear readout for the ESN reservoir: accepts one 16-bit fixed-point neuron state per handshake beat and multiply-accumulates it against a programmable weight vector. After N_NEURONS beats it rounds and saturates the sum and presents one output sample on a valid/ready port. It is the consumer of `neuron` `o_data` values, sitting between the reservoir and downstream logic.

## Interface
- `DATA_WIDTH`, 16: state/weight/output width, signed two's complement.
- `FRAC_BITS`, 12: fractional bits (Q4.12) of states, weights and output.
- `N_NEURONS`, 8: beats per output sample; ≥ 2.
- `ACC_WIDTH`, 2*DATA_WIDTH+$clog2(N_NEURONS): accumulator width; no internal overflow possible.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_data`  in  DATA_WIDTH  neuron state, signed.
- `i_valid`  in  1  `i_data` valid.
- `o_ready`  out  1  block accepts a state beat.
- `i_w_we`  in  1  weight write strobe.
- `i_w_addr`  in  $clog2(N_NEURONS)  weight index.
- `i_w_data`  in  DATA_WIDTH  weight value, signed.
- `o_data`  out  DATA_WIDTH  readout sample, signed.
- `o_valid`  out  1  `o_data` valid.
- `i_ready`  in  1  downstream accepts `o_data`.

## Operation
- States: ACCUM, ROUND, OUT. Reset enters ACCUM with acc=0, cnt=0.
- ACCUM:
  - `o_ready`=1.
  - On `i_valid & o_ready`: acc += sext(i_data*w[cnt]), cnt++.
  - On the N_NEURONS-th beat, go to ROUND.
- ROUND:
  - `o_ready`=0.
  - r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, arithmetic shift (round half up).
  - Saturate to [0x8000, 0x7FFF].
  - Register the result into `o_data`, set `o_valid`=1, go to OUT.
- OUT:
  - `o_ready`=0.
  - `o_data`/`o_valid` held stable until `i_ready`.
  - On `o_valid & i_ready`: `o_valid`=0, acc=0, cnt=0, go to ACCUM.
- Weights: N_NEURONS×DATA_WIDTH register file.
  - Written on `i_w_we` only in ACCUM with cnt==0; writes at any other time are ignored.
  - Write and state beat in the same cycle: the beat uses the old w[0]; the write lands.
  - Out-of-range `i_w_addr` (non-power-of-2 N) is ignored.
- `i_data` is ignored when `o_ready`=0.

## Timing
- Reset values:
  - `o_data`=0, `o_valid`=0, `o_ready`=0 while `rst`=1.
  - All weights=0, acc=0, cnt=0.
- `o_ready` is a registered-state decode (no combinational path from `i_valid`/`i_ready`).
- Last beat accepted at edge k → `o_valid`=1 after edge k+1.
- Output accepted at edge m → `o_ready`=1 after edge m. Peak rate is one sample per N_NEURONS+2 cycles.
- `rst` asserted mid-sample: the partial accumulation is discarded immediately. After release the block is in ACCUM at cnt=0 and the weights are 0.
- `i_valid` may drop between beats; cnt and acc hold.

## Structure
- Shared `esn_pkg`:
  - DATA_WIDTH and FRAC_BITS defaults, shared with `neuron`.
  - Q-format MIN/MAX constants.
  - State enum for ACCUM/ROUND/OUT.
- One sub-module, `esn_round_sat`: combinational ACC_WIDTH→DATA_WIDTH round-half-up and saturate. Parameterised on ACC_WIDTH, DATA_WIDTH and FRAC_BITS; reusable by `neuron`.

## Test plan
1. Basic sum: all w=0x1000 (1.0), 8 beats of 0x0800 (0.5), `i_ready`=1 → one `o_data`=0x4000; `o_valid` high exactly one cycle.
2. Saturation: all w=0x7FFF, states 0x7FFF → 0x7FFF. Then states 0x8000 with w=0x7FFF → 0x8000.
3. Rounding: w[0]=0x0001, others 0; state0=0x0800 → 0x0001. With state0=0x07FF → 0x0000. Negative half with state0=0xF800 → 0x0000.
4. Backpressure: `i_ready`=0 for 20 cycles after `o_valid`. Check `o_data` stable, `o_ready`=0, and extra `i_valid` beats not consumed. Release → next sample starts at cnt=0.
5. Gapped input plus mixed signs: w={1,-1,...} (0x1000/0xF000), states 0x1000 with random `i_valid` gaps → 0x0000. Weight writes attempted mid-sample are ignored, verified by the next sample.
6. Reset mid-operation: `rst` pulsed after 3 beats → all outputs 0 immediately, weights cleared. A full new sample afterwards yields 0x0000 until weights are reprogrammed.
